reg_file: RTL



---
 rtl/reg_file.sv | 124 ++++++++++++
 1 files changed

// File: rtl/reg_file.sv
// reg_file: MIPS general-purpose register file.
// 2**ADDR_W entries of WIDTH bits, two combinational read ports, one
// synchronous write port. After reset a clear sequencer zeroes every entry
// before writes are accepted. Entry 0 always reads zero.
// Optional feature: define REG_FILE_BYPASS_EN to forward same-cycle write
// data onto a read port whose address matches the write address.
module reg_file #(
   parameter int unsigned WIDTH  = 32,
   parameter int unsigned ADDR_W = 5
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              we,
   input  logic [ADDR_W-1:0] waddr,
   input  logic [WIDTH-1:0]  wdata,
   input  logic [ADDR_W-1:0] raddr1,
   input  logic [ADDR_W-1:0] raddr2,
   output logic [WIDTH-1:0]  rdata1,
   output logic [WIDTH-1:0]  rdata2,
   output logic              ready
);

   localparam int unsigned DEPTH = 2 ** ADDR_W;

   typedef enum logic {
      CLEAR = 1'b0,
      RUN   = 1'b1
   } state_e;

   state_e            state_q;
   logic [ADDR_W-1:0] cnt_q;
   logic              ready_q;
   logic [WIDTH-1:0]  mem_q [DEPTH];

   // Single physical write port, shared by the clear sequencer and writeback.
   logic              wr_en_d;
   logic [ADDR_W-1:0] wr_addr_d;
   logic [WIDTH-1:0]  wr_data_d;

   // Clear/run sequencer with registered ready.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= CLEAR;
         cnt_q   <= '0;
         ready_q <= 1'b0;
      end else begin
         case (state_q)
            CLEAR: begin
               cnt_q <= cnt_q + 1'b1;
               if (cnt_q == '1) begin
                  state_q <= RUN;
                  ready_q <= 1'b1;
               end
            end
            RUN: begin
               ready_q <= 1'b1;
            end
            default: begin
               state_q <= CLEAR;
               cnt_q   <= '0;
               ready_q <= 1'b0;
            end
         endcase
      end
   end

   // Write-port mux: clear zeroes mem[cnt]; in RUN writes to entry 0 are dropped.
   always_comb begin
      wr_en_d   = 1'b0;
      wr_addr_d = cnt_q;
      wr_data_d = '0;
      if (!rst) begin
         if (state_q == CLEAR) begin
            wr_en_d = 1'b1;
         end else if (we && (waddr != '0)) begin
            wr_en_d   = 1'b1;
            wr_addr_d = waddr;
            wr_data_d = wdata;
         end
      end
   end

   // Storage array; reset does not touch its contents.
   always_ff @(posedge clk) begin
      if (wr_en_d) begin
         mem_q[wr_addr_d] <= wr_data_d;
      end
   end

   // Read port 1: zero while clearing or for entry 0.
   always_comb begin
      rdata1 = '0;
      if (ready_q && (raddr1 != '0)) begin
`ifdef REG_FILE_BYPASS_EN
         if (we && (waddr == raddr1)) begin
            rdata1 = wdata;
         end else begin
            rdata1 = mem_q[raddr1];
         end
`else
         rdata1 = mem_q[raddr1];
`endif
      end
   end

   // Read port 2: identical to port 1.
   always_comb begin
      rdata2 = '0;
      if (ready_q && (raddr2 != '0)) begin
`ifdef REG_FILE_BYPASS_EN
         if (we && (waddr == raddr2)) begin
            rdata2 = wdata;
         end else begin
            rdata2 = mem_q[raddr2];
         end
`else
         rdata2 = mem_q[raddr2];
`endif
      end
   end

   assign ready = ready_q;

endmodule
